// File: rtl/command_credit_tracker_pkg.sv
// Shared types and constants for the PSL command credit / tag tracker.
package command_credit_tracker_pkg;

    localparam int PSL_TAG_WIDTH    = 8;
    localparam int PSL_CREDIT_WIDTH = 8;

    // PSL response code for a successfully completed command.
    localparam logic [7:0] DONE = 8'h00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } tracker_state_t;

    // Number of set bits in a bitmap of up to 64 tags.
    function automatic logic [6:0] popcount64(input logic [63:0] bits);
        logic [6:0] total;
        total = '0;
        for (int i = 0; i < 64; i++) begin
            total = total + 7'(bits[i]);
        end
        return total;
    endfunction

endpackage

// File: rtl/command_credit_tracker_if.sv
// Work-element / PSL facing signals of the credit tracker.
// master = the side driving requests and responses, slave = the tracker.
interface command_credit_tracker_if
    import command_credit_tracker_pkg::*;
#(
    parameter int TAG_WIDTH    = PSL_TAG_WIDTH,
    parameter int CREDIT_WIDTH = PSL_CREDIT_WIDTH
);
    logic                    job_start;
    logic                    job_reset;
    logic [CREDIT_WIDTH-1:0] room;
    logic                    req_valid;
    logic                    req_ready;
    logic                    issue_valid;
    logic [TAG_WIDTH-1:0]    issue_tag;
    logic                    resp_valid;
    logic [TAG_WIDTH-1:0]    resp_tag;
    logic [7:0]              resp_code;
    logic [8:0]              resp_credits;
    logic                    done_valid;
    logic [TAG_WIDTH-1:0]    done_tag;
    logic [7:0]              done_code;
    logic [CREDIT_WIDTH-1:0] credits;
    logic [6:0]              outstanding;
    logic                    drained;
    logic                    error;

    modport master (
        output job_start, job_reset, room, req_valid,
               resp_valid, resp_tag, resp_code, resp_credits,
        input  req_ready, issue_valid, issue_tag, done_valid, done_tag,
               done_code, credits, outstanding, drained, error
    );

    modport slave (
        input  job_start, job_reset, room, req_valid,
               resp_valid, resp_tag, resp_code, resp_credits,
        output req_ready, issue_valid, issue_tag, done_valid, done_tag,
               done_code, credits, outstanding, drained, error
    );

endinterface

// File: rtl/command_credit_tracker_tag_allocator.sv
// Busy bitmap for command tags: hands out the lowest free tag, frees tags
// on responses and keeps a registered count of busy tags.
module command_credit_tracker_tag_allocator
    import command_credit_tracker_pkg::*;
#(
    parameter int TAG_COUNT = 16,
    parameter int IDX_W     = $clog2(TAG_COUNT)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 alloc,
    input  logic                 free_valid,
    input  logic [IDX_W-1:0]     free_idx,
    output logic                 any_free,
    output logic [IDX_W-1:0]     alloc_idx,
    output logic [TAG_COUNT-1:0] busy,
    output logic [6:0]           outstanding
);

    logic [TAG_COUNT-1:0] busy_reg;
    logic [TAG_COUNT-1:0] busy_next;
    logic [6:0]           outstanding_reg;

    // Lowest free index; the scan sees only pre-edge state, so a tag being
    // freed this cycle is never offered and cannot collide with an alloc.
    always_comb begin
        alloc_idx = '0;
        for (int i = TAG_COUNT - 1; i >= 0; i--) begin
            if (!busy_reg[i]) begin
                alloc_idx = i[IDX_W-1:0];
            end
        end
        any_free = ~&busy_reg;
    end

    for (genvar gi = 0; gi < TAG_COUNT; gi++) begin : g_busy
        assign busy_next[gi] = (busy_reg[gi] | (alloc && (alloc_idx == IDX_W'(gi))))
                             & ~(free_valid && (free_idx == IDX_W'(gi)));
    end

    // Bitmap and its population count move on the same edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_reg        <= '0;
            outstanding_reg <= '0;
        end else begin
            busy_reg        <= busy_next;
            outstanding_reg <= popcount64(64'(busy_next));
        end
    end

    assign busy        = busy_reg;
    assign outstanding = outstanding_reg;

endmodule

// File: rtl/command_credit_tracker.sv
// Owns PSL command credits and tag allocation: grants issue slots when a
// credit and a tag both exist, matches responses to tags, and drains
// in-flight commands on job reset before reporting idle.
module command_credit_tracker
    import command_credit_tracker_pkg::*;
#(
    parameter int TAG_COUNT    = 16,
    parameter int TAG_WIDTH    = PSL_TAG_WIDTH,
    parameter int CREDIT_WIDTH = PSL_CREDIT_WIDTH
) (
    input  logic                     clock,
    input  logic                     reset_n,
    command_credit_tracker_if.slave  bus
);

    localparam int IDX_W  = $clog2(TAG_COUNT);
    localparam int CALC_W = CREDIT_WIDTH + 2;

    tracker_state_t          state_reg;
    logic [CREDIT_WIDTH-1:0] credits_reg;
    logic [CREDIT_WIDTH-1:0] credits_next;
    logic [CREDIT_WIDTH-1:0] room_cap_reg;
    logic                    error_reg;
    logic                    issue_valid_reg;
    logic [TAG_WIDTH-1:0]    issue_tag_reg;
    logic                    done_valid_reg;
    logic [TAG_WIDTH-1:0]    done_tag_reg;
    logic [7:0]              done_code_reg;
    logic                    drained_reg;

    logic                    any_free;
    logic [IDX_W-1:0]        alloc_idx;
    logic [TAG_COUNT-1:0]    busy;
    logic [6:0]              outstanding;

    logic                    req_ready;
    logic                    issue_fire;
    logic                    resp_in_range;
    logic [IDX_W-1:0]        resp_idx;
    logic                    resp_ok;
    logic                    resp_bad;
    logic                    drain_empty;

    logic signed [CALC_W-1:0] credit_sum;
    logic signed [CALC_W-1:0] resp_delta;
    logic signed [CALC_W-1:0] issue_step;
    logic signed [CALC_W-1:0] cap_ext;
    logic                     clamp_err;

    command_credit_tracker_tag_allocator #(
        .TAG_COUNT (TAG_COUNT)
    ) u_tag_allocator (
        .clock       (clock),
        .reset_n     (reset_n),
        .alloc       (issue_fire),
        .free_valid  (resp_ok),
        .free_idx    (resp_idx),
        .any_free    (any_free),
        .alloc_idx   (alloc_idx),
        .busy        (busy),
        .outstanding (outstanding)
    );

    // Grant and response classification for the current cycle.
    always_comb begin
        req_ready     = (state_reg == ACTIVE) && (credits_reg != '0) && any_free && !bus.job_reset;
        issue_fire    = bus.req_valid && req_ready;
        resp_in_range = (32'(bus.resp_tag) < TAG_COUNT);
        resp_idx      = bus.resp_tag[IDX_W-1:0];
        resp_ok       = bus.resp_valid && (state_reg != IDLE) && resp_in_range && busy[resp_idx];
        resp_bad      = bus.resp_valid && !resp_ok;
        // No issues happen in DRAIN, so the last busy tag going away is the
        // only way the count can reach zero at this edge.
        drain_empty   = (outstanding == 7'd0) || ((outstanding == 7'd1) && resp_ok);
    end

    // Signed credit update with clamping to [0, room_cap].
    always_comb begin
        resp_delta   = resp_ok ? CALC_W'($signed(bus.resp_credits)) : '0;
        issue_step   = $signed({{(CALC_W-1){1'b0}}, issue_fire});
        cap_ext      = $signed({2'b00, room_cap_reg});
        credit_sum   = $signed({2'b00, credits_reg}) + resp_delta - issue_step;
        credits_next = credits_reg;
        clamp_err    = 1'b0;
        if (issue_fire || resp_ok) begin
            if (credit_sum < 0) begin
                credits_next = '0;
                clamp_err    = 1'b1;
            end else if (credit_sum > cap_ext) begin
                credits_next = room_cap_reg;
                clamp_err    = 1'b1;
            end else begin
                credits_next = credit_sum[CREDIT_WIDTH-1:0];
            end
        end
    end

    // Job FSM with registered issue/done/drained strobes and sticky error.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            credits_reg     <= '0;
            room_cap_reg    <= '0;
            error_reg       <= 1'b0;
            issue_valid_reg <= 1'b0;
            issue_tag_reg   <= '0;
            done_valid_reg  <= 1'b0;
            done_tag_reg    <= '0;
            done_code_reg   <= '0;
            drained_reg     <= 1'b0;
        end else begin
            issue_valid_reg <= issue_fire;
            if (issue_fire) begin
                issue_tag_reg <= TAG_WIDTH'(alloc_idx);
            end
            done_valid_reg <= resp_ok;
            if (resp_ok) begin
                done_tag_reg  <= bus.resp_tag;
                done_code_reg <= bus.resp_code;
            end
            drained_reg <= 1'b0;
            if (resp_bad || clamp_err) begin
                error_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (bus.job_reset) begin
                        drained_reg <= 1'b1;
                    end else if (bus.job_start) begin
                        state_reg    <= ACTIVE;
                        credits_reg  <= bus.room;
                        room_cap_reg <= bus.room;
                        error_reg    <= 1'b0;
                    end
                end
                ACTIVE: begin
                    credits_reg <= credits_next;
                    if (bus.job_reset) begin
                        if ((outstanding != 7'd0) || bus.resp_valid) begin
                            state_reg <= DRAIN;
                        end else begin
                            state_reg   <= IDLE;
                            drained_reg <= 1'b1;
                            credits_reg <= '0;
                        end
                    end
                end
                DRAIN: begin
                    credits_reg <= credits_next;
                    if (drain_empty) begin
                        state_reg   <= IDLE;
                        drained_reg <= 1'b1;
                        credits_reg <= '0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.req_ready   = req_ready;
    assign bus.issue_valid = issue_valid_reg;
    assign bus.issue_tag   = issue_tag_reg;
    assign bus.done_valid  = done_valid_reg;
    assign bus.done_tag    = done_tag_reg;
    assign bus.done_code   = done_code_reg;
    assign bus.credits     = credits_reg;
    assign bus.outstanding = outstanding;
    assign bus.drained     = drained_reg;
    assign bus.error       = error_reg;

endmodule

// File: tb/tb_command_credit_tracker.sv
// Directed plus randomized bench for command_credit_tracker, checked every
// cycle against an integer/array reference model of the tracker rules.
module tb_command_credit_tracker;
    import command_credit_tracker_pkg::*;

    localparam int TAG_COUNT = 16;
    localparam int TW        = 8;
    localparam int CW        = 8;
    localparam int S_IDLE    = 0;
    localparam int S_ACTIVE  = 1;
    localparam int S_DRAIN   = 2;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    command_credit_tracker_if #(.TAG_WIDTH(TW), .CREDIT_WIDTH(CW)) bus();

    command_credit_tracker #(
        .TAG_COUNT    (TAG_COUNT),
        .TAG_WIDTH    (TW),
        .CREDIT_WIDTH (CW)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_state;
    bit m_busy [TAG_COUNT];
    int m_credits;
    int m_cap;
    int m_err;
    int e_iv, e_itag, e_dv, e_dtag, e_dcode, e_drained;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int busy_count();
        int n = 0;
        for (int i = 0; i < TAG_COUNT; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    function automatic int lowest_free();
        for (int i = 0; i < TAG_COUNT; i++) if (!m_busy[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_state = S_IDLE;
        for (int i = 0; i < TAG_COUNT; i++) m_busy[i] = 1'b0;
        m_credits = 0; m_cap = 0; m_err = 0;
        e_iv = 0; e_itag = 0; e_dv = 0; e_dtag = 0; e_dcode = 0; e_drained = 0;
    endtask

    task automatic check_outputs(input string pfx);
        chk({pfx, "_issue_valid"}, 32'(bus.issue_valid), e_iv);
        if (e_iv != 0) chk({pfx, "_issue_tag"}, 32'(bus.issue_tag), e_itag);
        chk({pfx, "_done_valid"}, 32'(bus.done_valid), e_dv);
        if (e_dv != 0) begin
            chk({pfx, "_done_tag"}, 32'(bus.done_tag), e_dtag);
            chk({pfx, "_done_code"}, 32'(bus.done_code), e_dcode);
        end
        chk({pfx, "_credits"}, 32'(bus.credits), m_credits);
        chk({pfx, "_outstanding"}, 32'(bus.outstanding), busy_count());
        chk({pfx, "_drained"}, 32'(bus.drained), e_drained);
        chk({pfx, "_error"}, 32'(bus.error), m_err);
    endtask

    // One clock: check req_ready, predict the edge, then check outputs.
    task automatic tick();
        int rdy, fire, tag, rt, rok, bad, clamp, sum, cnt_before;
        #1;
        cnt_before = busy_count();
        rdy = (m_state == S_ACTIVE && m_credits != 0 && cnt_before < TAG_COUNT && !bus.job_reset) ? 1 : 0;
        chk("req_ready", 32'(bus.req_ready), rdy);
        fire = (bus.req_valid && rdy != 0) ? 1 : 0;
        tag  = lowest_free();
        rt   = int'(bus.resp_tag);
        rok  = 0;
        if (bus.resp_valid && m_state != S_IDLE && rt < TAG_COUNT) rok = m_busy[rt] ? 1 : 0;
        bad  = (bus.resp_valid && rok == 0) ? 1 : 0;
        sum  = m_credits - fire + ((rok != 0) ? int'($signed(bus.resp_credits)) : 0);
        clamp = 0;
        if (fire != 0 || rok != 0) begin
            if (sum < 0) begin sum = 0; clamp = 1; end
            else if (sum > m_cap) begin sum = m_cap; clamp = 1; end
        end else begin
            sum = m_credits;
        end
        e_iv = fire;
        if (fire != 0) e_itag = tag;
        e_dv = rok;
        if (rok != 0) begin e_dtag = rt; e_dcode = int'(bus.resp_code); end
        e_drained = 0;
        if (bad != 0 || clamp != 0) m_err = 1;
        if (fire != 0) m_busy[tag] = 1'b1;
        if (rok != 0) m_busy[rt] = 1'b0;
        case (m_state)
            S_IDLE: begin
                if (bus.job_reset) e_drained = 1;
                else if (bus.job_start) begin
                    m_state = S_ACTIVE; m_credits = int'(bus.room); m_cap = int'(bus.room); m_err = 0;
                end
            end
            S_ACTIVE: begin
                m_credits = sum;
                if (bus.job_reset) begin
                    if (cnt_before > 0 || bus.resp_valid) m_state = S_DRAIN;
                    else begin m_state = S_IDLE; e_drained = 1; m_credits = 0; end
                end
            end
            default: begin
                m_credits = sum;
                if (busy_count() == 0) begin m_state = S_IDLE; e_drained = 1; m_credits = 0; end
            end
        endcase
        @(posedge clock);
        #1;
        check_outputs("cyc");
    endtask

    task automatic set_resp(input logic v, input int tag, input int code, input int cr);
        bus.resp_valid   = v;
        bus.resp_tag     = TW'(tag);
        bus.resp_code    = 8'(code);
        bus.resp_credits = 9'(cr);
    endtask

    initial begin
        int rc, pick;
        bus.job_start = 1'b0; bus.job_reset = 1'b0; bus.room = '0; bus.req_valid = 1'b0;
        set_resp(1'b0, 0, 0, 0);
        model_reset();

        // Reset state
        #3;
        chk("rst_req_ready", 32'(bus.req_ready), 0);
        check_outputs("rst");
        @(negedge clock); reset_n = 1'b1;
        @(posedge clock); #1;

        // Burst of 4 with room=4
        bus.job_start = 1'b1; bus.room = 8'd4;
        tick();
        bus.job_start = 1'b0;
        chk("start_credits", 32'(bus.credits), 4);
        bus.req_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("burst_issue_valid", 32'(bus.issue_valid), (i < 4) ? 1 : 0);
            if (i < 4) chk("burst_tag", 32'(bus.issue_tag), i);
        end
        chk("burst_credits", 32'(bus.credits), 0);
        chk("burst_outstanding", 32'(bus.outstanding), 4);
        bus.req_valid = 1'b0;

        // Response tag 2 returns a credit, next grant reuses tag 2
        set_resp(1'b1, 2, DONE, 1);
        tick();
        chk("resp2_done_tag", 32'(bus.done_tag), 2);
        chk("resp2_credits", 32'(bus.credits), 1);
        set_resp(1'b0, 0, 0, 0);
        bus.req_valid = 1'b1;
        tick();
        chk("reissue_tag", 32'(bus.issue_tag), 2);
        bus.req_valid = 1'b0;

        // Free tag 3 for a credit, then issue alongside response for tag 0
        set_resp(1'b1, 3, DONE, 1);
        tick();
        bus.req_valid = 1'b1;
        set_resp(1'b1, 0, 8'h5a, 1);
        tick();
        chk("same_cycle_tag", 32'(bus.issue_tag), 3);
        chk("same_cycle_credits", 32'(bus.credits), 1);
        chk("same_cycle_outstanding", 32'(bus.outstanding), 3);
        bus.req_valid = 1'b0;

        // Bad response, then credit overflow clamp
        set_resp(1'b1, 5, DONE, 0);
        tick();
        chk("bad_tag_error", 32'(bus.error), 1);
        chk("bad_tag_no_done", 32'(bus.done_valid), 0);
        set_resp(1'b1, 1, DONE, 10);
        tick();
        chk("clamp_credits", 32'(bus.credits), 4);
        chk("clamp_error", 32'(bus.error), 1);
        set_resp(1'b0, 0, 0, 0);

        // Third outstanding, then job_reset drains
        bus.req_valid = 1'b1;
        tick();
        chk("pre_drain_outstanding", 32'(bus.outstanding), 3);
        bus.job_reset = 1'b1;
        #1;
        chk("job_reset_ready", 32'(bus.req_ready), 0);
        tick();
        bus.job_reset = 1'b0;
        set_resp(1'b1, 0, DONE, 0); tick();
        set_resp(1'b1, 2, DONE, 0); tick();
        chk("drain_not_yet", 32'(bus.drained), 0);
        set_resp(1'b1, 3, DONE, 0); tick();
        chk("drain_pulse", 32'(bus.drained), 1);
        chk("drain_credits", 32'(bus.credits), 0);
        set_resp(1'b0, 0, 0, 0);
        tick();
        chk("drain_pulse_end", 32'(bus.drained), 0);
        bus.req_valid = 1'b0;

        // job_reset beats job_start in IDLE
        bus.job_start = 1'b1; bus.job_reset = 1'b1; bus.room = 8'd5;
        tick();
        chk("reset_wins_drained", 32'(bus.drained), 1);
        chk("reset_wins_credits", 32'(bus.credits), 0);
        bus.job_reset = 1'b0; bus.room = 8'd6;
        tick();
        chk("start_clears_error", 32'(bus.error), 0);
        bus.job_start = 1'b0;

        // Async reset mid-burst
        bus.req_valid = 1'b1;
        tick(); tick();
        chk("pre_async_outstanding", 32'(bus.outstanding), 2);
        #2; reset_n = 1'b0; bus.req_valid = 1'b0;
        #1;
        model_reset();
        chk("async_req_ready", 32'(bus.req_ready), 0);
        check_outputs("async");
        @(negedge clock); reset_n = 1'b1;
        @(posedge clock); #1;
        bus.job_start = 1'b1; bus.room = 8'd2;
        tick();
        bus.job_start = 1'b0; bus.req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i < 2) chk("post_reset_tag", 32'(bus.issue_tag), i);
        end
        chk("post_reset_exhausted", 32'(bus.issue_valid), 0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            bus.job_start = (m_state == S_IDLE) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 30) == 0);
            bus.job_reset = ($urandom_range(0, 40) == 0);
            bus.room      = CW'($urandom_range(0, 12));
            bus.req_valid = $urandom_range(0, 1) == 1;
            rc = int'($urandom_range(0, 5)) - 2;
            if (busy_count() > 0 && $urandom_range(0, 99) < 85) begin
                pick = int'($urandom_range(0, TAG_COUNT - 1));
                for (int k = 0; k < TAG_COUNT && !m_busy[pick]; k++) pick = (pick + 1) % TAG_COUNT;
            end else begin
                pick = int'($urandom_range(0, TAG_COUNT + 3));
            end
            set_resp($urandom_range(0, 99) < 45, pick, int'($urandom_range(0, 255)), rc);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
